// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit value, run length} words into packed bytes,
// first decoded bit in bit 0, and flushes a zero-padded partial byte at end of stream.
//
// state     | meaning
// IDLE      | wait for a run word or end of stream
// REQ       | pulse rd_req to the input FIFO
// WAIT      | FIFO read latency
// LOAD      | capture run value and length
// EXPAND    | shift one run bit per cycle into the byte buffer
// WAIT_SEND | byte complete (or flushing), wait for output FIFO space
// WRITE     | pulse wr_req with the assembled byte
// DONE      | stream fully decoded, hold until reset
module rle_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic        recv_ready,
  input  logic        send_ready,
  input  logic [23:0] in_data,
  input  logic        end_of_stream,
  output logic        rd_req,
  output logic        wr_req,
  output logic [7:0]  out_data,
  output logic        done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ       = 3'd1;
  localparam logic [2:0] WAIT      = 3'd2;
  localparam logic [2:0] LOAD      = 3'd3;
  localparam logic [2:0] EXPAND    = 3'd4;
  localparam logic [2:0] WAIT_SEND = 3'd5;
  localparam logic [2:0] WRITE     = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  logic [2:0]  r_state;
  logic        r_value;
  logic [22:0] r_remaining;
  logic [3:0]  r_fill;
  logic [7:0]  r_byte_buf;
  logic        r_flush;

  logic [2:0]  w_next;
  logic [3:0]  w_fill_inc;
  logic [22:0] w_rem_dec;

  assign w_fill_inc = r_fill + 4'd1;
  assign w_rem_dec  = r_remaining - 23'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (recv_ready)
          w_next = REQ;
        else if (end_of_stream)
          w_next = (r_fill != 4'd0) ? WAIT_SEND : DONE;
      end
      REQ:    w_next = WAIT;
      WAIT:   w_next = LOAD;
      LOAD:   w_next = (in_data[22:0] == 23'd0) ? IDLE : EXPAND;
      EXPAND: begin
        if (w_fill_inc == 4'd8)
          w_next = WAIT_SEND;
        else if (w_rem_dec == 23'd0)
          w_next = IDLE;
      end
      WAIT_SEND: if (send_ready) w_next = WRITE;
      WRITE: begin
        if (r_remaining != 23'd0)
          w_next = EXPAND;
        else if (r_flush)
          w_next = DONE;
        else
          w_next = IDLE;
      end
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean decode of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_value     <= 1'b0;
      r_remaining <= 23'd0;
      r_fill      <= 4'd0;
      r_byte_buf  <= 8'd0;
      r_flush     <= 1'b0;
      rd_req      <= 1'b0;
      wr_req      <= 1'b0;
      out_data    <= 8'd0;
      done        <= 1'b0;
    end else begin
      r_state <= w_next;
      rd_req  <= (w_next == REQ);
      wr_req  <= (w_next == WRITE);
      done    <= (w_next == DONE);
      if (w_next == WRITE)
        out_data <= r_byte_buf;
      case (r_state)
        IDLE: begin
          if (!recv_ready && end_of_stream && (r_fill != 4'd0))
            r_flush <= 1'b1;
        end
        LOAD: begin
          r_value     <= in_data[23];
          r_remaining <= in_data[22:0];
        end
        EXPAND: begin
          r_byte_buf[r_fill[2:0]] <= r_value;
          r_fill                  <= w_fill_inc;
          r_remaining             <= w_rem_dec;
        end
        WRITE: begin
          r_byte_buf <= 8'd0;
          r_fill     <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_dec.sv
// Bench for rle_dec: a FIFO model feeds run words, a bit-level reference model
// builds the expected byte stream, directed cases plus randomized streams.
module tb_rle_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recv_ready;
  logic        send_ready = 1'b1;
  logic [23:0] in_data = 24'd0;
  logic        end_of_stream = 1'b0;
  logic        rd_req;
  logic        wr_req;
  logic [7:0]  out_data;
  logic        done;

  rle_dec dut (
    .clk           (clk),
    .rst           (rst),
    .recv_ready    (recv_ready),
    .send_ready    (send_ready),
    .in_data       (in_data),
    .end_of_stream (end_of_stream),
    .rd_req        (rd_req),
    .wr_req        (wr_req),
    .out_data      (out_data),
    .done          (done)
  );

  always #5 clk = ~clk;

  logic [23:0] words [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          base   = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          rand_send = 1'b0;
  logic [7:0]  got   [$];
  logic [7:0]  exp_q [$];

  // Input FIFO model: data appears the cycle after rd_req and is held.
  assign recv_ready = (rd_ptr != wr_ptr);
  always @(posedge clk) begin
    if (rst)
      rd_ptr <= wr_ptr;
    else if (rd_req) begin
      in_data <= words[rd_ptr % 512];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (wr_req) got.push_back(out_data);
    chk("rd_wr_overlap", {31'd0, rd_req & wr_req}, 32'd0);
    if (rand_send) send_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic val, input int len);
    words[wr_ptr % 512] = {val, len[22:0]};
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    end_of_stream = 1'b0;
    send_ready = 1'b1;
    rand_send = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
    base = wr_ptr;
  endtask

  task automatic build_exp();
    int nb;
    logic [7:0] b;
    logic [23:0] w;
    exp_q.delete();
    nb = 0;
    b = 8'd0;
    for (int i = base; i < wr_ptr; i++) begin
      w = words[i % 512];
      for (int k = 0; k < int'(w[22:0]); k++) begin
        b[nb] = w[23];
        nb++;
        if (nb == 8) begin
          exp_q.push_back(b);
          b = 8'd0;
          nb = 0;
        end
      end
    end
    if (nb != 0) exp_q.push_back(b);
  endtask

  task automatic run_stream(input string tag, input int budget);
    int n;
    end_of_stream = 1'b1;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    build_exp();
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", {24'd0, out_data}, 32'd0);

    // {1,3},{0,5} -> 0x07
    push(1'b1, 3); push(1'b0, 5);
    run_stream("concat", 200);
    chk("concat_first", {24'd0, got.size() > 0 ? got[0] : 8'hxx}, 32'h07);

    // {1,12} -> 0xFF, 0x0F padded
    do_reset();
    push(1'b1, 12);
    run_stream("pad", 200);

    // Zero-length word consumes one read, emits nothing
    do_reset();
    push(1'b0, 0); push(1'b1, 8);
    run_stream("zero_len", 200);
    chk("zero_len_reads", rd_ptr - base, 2);

    // Output stall with send_ready low
    do_reset();
    send_ready = 1'b0;
    push(1'b1, 20);
    end_of_stream = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("stall_nowrite", got.size(), 0);
    chk("stall_out", {24'd0, out_data}, 32'd0);
    chk("stall_done", {31'd0, done}, 32'd0);
    send_ready = 1'b1;
    run_stream("stall", 200);

    // Reset in EXPAND after 3 bits of {1,6}
    do_reset();
    push(1'b1, 6);
    begin
      int n;
      n = 0;
      while (!rd_req && n < 20) begin tick(); n++; end
      chk("mid_rst_rdreq", {31'd0, rd_req}, 32'd1);
    end
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rd", {31'd0, rd_req}, 32'd0);
    chk("mid_rst_wr", {31'd0, wr_req}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_out", {24'd0, out_data}, 32'd0);
    chk("mid_rst_nowrite", got.size(), 0);
    rst = 1'b0;
    base = wr_ptr;
    push(1'b0, 8);
    run_stream("after_rst", 200);

    // End of stream with nothing buffered
    do_reset();
    end_of_stream = 1'b1;
    tick();
    chk("eos_empty_done", {31'd0, done}, 32'd1);
    chk("eos_empty_nowrite", got.size(), 0);

    // recv_ready wins over end_of_stream
    do_reset();
    push(1'b1, 8);
    end_of_stream = 1'b1;
    tick();
    chk("prio_rdreq", {31'd0, rd_req}, 32'd1);
    chk("prio_done", {31'd0, done}, 32'd0);
    run_stream("prio", 200);

    // Long run spanning many bytes, random back-pressure
    do_reset();
    rand_send = 1'b1;
    push(1'b1, 1000); push(1'b0, 3); push(1'b1, 1);
    run_stream("long", 4000);

    // Maximum run length: verify steady progress without early completion
    do_reset();
    rand_send = 1'b1;
    push(1'b1, 23'h7FFFFF);
    end_of_stream = 1'b1;
    for (int i = 0; i < 3000; i++) tick();
    chk("max_not_done", {31'd0, done}, 32'd0);
    chk("max_progress", {31'd0, got.size() >= 200}, 32'd1);
    for (int i = 0; i < got.size() && i < 64; i++)
      chk("max_byte", {24'd0, got[i]}, 32'hFF);

    // Randomized streams
    for (int t = 0; t < 10; t++) begin
      int nw;
      do_reset();
      rand_send = 1'b1;
      nw = $urandom_range(1, 10);
      for (int j = 0; j < nw; j++) begin
        if ($urandom_range(0, 3) == 0)
          push(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        else
          push(1'($urandom_range(0, 1)), $urandom_range(1, 30));
      end
      run_stream("rand", 6000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
